// File: rtl/seq_detector_onehot.sv
// seq_detector_onehot: one-hot Mealy detector for a fixed bit pattern, with
// elaboration-time KMP fallback transitions and a saturating match counter.
module seq_detector_onehot #(
    parameter int              LEN     = 4,
    parameter logic [LEN-1:0]  PATTERN = 4'b1011,
    parameter bit              OVERLAP = 1'b1,
    parameter int              COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               en,
    input  logic               din,
    input  logic               clr,
    output logic               match,
    output logic               match_q,
    output logic [LEN-1:0]     state,
    output logic [COUNT_W-1:0] count
);
    localparam logic [LEN-1:0] S0 = LEN'(1);

    // longest pattern prefix that is a suffix of (first k pattern bits, b)
    function automatic int target(int k, bit b);
        int res;
        int idx;
        bit ok;
        bit sb;
        res = 0;
        for (int j = 1; j < LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    idx = k + 1 - j + i;
                    sb  = (idx == k) ? b : PATTERN[LEN-1-idx];
                    if (sb != PATTERN[LEN-1-i]) ok = 1'b0;
                end
                if (ok) res = j;
            end
        end
        return (k == LEN - 1 && b == PATTERN[0] && !OVERLAP) ? 0 : res;
    endfunction

    logic [LEN-1:0] hop [LEN];
    logic [LEN-1:0] adv;
    logic [LEN-1:0] state_d;
    logic           onehot;

    for (genvar k = 0; k < LEN; k++) begin : g_hop
        localparam int T0 = target(k, 1'b0);
        localparam int T1 = target(k, 1'b1);
        assign hop[k] = state[k] ? (din ? S0 << T1 : S0 << T0) : '0;
    end

    assign onehot = (|state) && ~|(state & (state - S0));
    assign match  = en & state[LEN-1] & (din == PATTERN[0]) & ~clr;

    always_comb begin
        adv = '0;
        for (int k = 0; k < LEN; k++) adv |= hop[k];
        state_d = (!onehot || clr) ? S0 : en ? adv : state;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= S0;
            match_q <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_d;
            match_q <= match;
            if (clr) count <= '0;
            else if (match && count != '1) count <= count + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_seq_detector_onehot.sv
// tb_seq_detector_onehot: directed vectors against three parameterisations
// (overlapping, non-overlapping, 2-bit counter) sharing one input stream.
module tb_seq_detector_onehot;
    logic clk = 1'b0;
    logic rst_b, en, din, clr;
    logic       match_ov, match_q_ov, match_no, match_q_no, match_sat, match_q_sat;
    logic [3:0] state_ov, state_no, state_sat;
    logic [7:0] count_ov, count_no;
    logic [1:0] count_sat;
    logic       mo, mn, ms;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_detector_onehot #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8)) u_ov (
        .clk(clk), .rst_b(rst_b), .en(en), .din(din), .clr(clr),
        .match(match_ov), .match_q(match_q_ov), .state(state_ov), .count(count_ov));
    seq_detector_onehot #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(8)) u_no (
        .clk(clk), .rst_b(rst_b), .en(en), .din(din), .clr(clr),
        .match(match_no), .match_q(match_q_no), .state(state_no), .count(count_no));
    seq_detector_onehot #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(2)) u_sat (
        .clk(clk), .rst_b(rst_b), .en(en), .din(din), .clr(clr),
        .match(match_sat), .match_q(match_q_sat), .state(state_sat), .count(count_sat));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic b);
        en  = 1'b1;
        din = b;
        clr = 1'b0;
        #1;
        mo = match_ov;
        mn = match_no;
        ms = match_sat;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic clear_all();
        clr = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    logic [6:0] stream = 7'b1011011;
    logic [6:0] exp_ov = 7'b0001001;
    logic [6:0] exp_no = 7'b0001000;
    logic [4:0] fb     = 5'b11011;
    logic [3:0] pat    = 4'b1011;
    logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst_b = 1'b0; en = 1'b1; clr = 1'b0; din = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din = ~din;
            #1;
            check("rst_state", state_ov, 4'b0001);
            check("rst_count", count_ov, 0);
            check("rst_match", match_ov, 0);
            check("rst_match_q", match_q_ov, 0);
        end
        @(posedge clk);
        #1;
        en = 1'b0;
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            send(stream[6-i]);
            check("ov_match", mo, exp_ov[6-i]);
            check("no_match", mn, exp_no[6-i]);
            if (i == 3) begin
                check("ov_state_after_match", state_ov, 4'b0010);
                check("ov_match_q", match_q_ov, 1);
                check("no_state_after_match", state_no, 4'b0001);
            end
        end
        check("ov_count", count_ov, 2);
        check("no_count", count_no, 1);

        clear_all();
        check("clr_count", count_ov, 0);
        check("clr_state", state_ov, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            send(fb[4-i]);
            check("fb_match", mo, i == 4);
            if (i == 1) check("fb_state_bit2", state_ov, 4'b0010);
        end
        check("fb_count", count_ov, 1);
        for (int i = 0; i < 3; i++) begin
            en = 1'b0;
            din = 1'b1;
            #1;
            check("hold_match", match_ov, 0);
            @(posedge clk);
            #1;
            check("hold_state", state_ov, 4'b0010);
            check("hold_count", count_ov, 1);
            check("hold_match_q", match_q_ov, 0);
        end

        clear_all();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) send(pat[3-i]);
            check("sat_match", ms, 1);
            check("sat_count", count_sat, exp_sat[r]);
        end
        send(1'b0);
        send(1'b1);
        check("sat_state_s3", state_sat, 4'b1000);
        en = 1'b1; din = 1'b1; clr = 1'b1;
        #1;
        check("clr_blocks_match", match_sat, 0);
        @(posedge clk);
        #1;
        check("clr_sat_state", state_sat, 4'b0001);
        check("clr_sat_count", count_sat, 0);
        check("clr_sat_match_q", match_q_sat, 0);
        clr = 1'b0; en = 1'b0;

        for (int m = 0; m < 2; m++) begin
            en = 1'(m);
            din = 1'b1;
            force u_ov.state = 4'b0110;
            #1;
            release u_ov.state;
            check("forced_state", state_ov, 4'b0110);
            @(posedge clk);
            #1;
            check(m ? "recover_en1" : "recover_en0", state_ov, 4'b0001);
        end
        en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
